// File: rtl/core_run_ctrl_pkg.sv
// core_run_ctrl_pkg
//   Shared types and widths for the run/halt/single-step sequencer of the
//   single-cycle RV32I core.
//   - run_state_e : sequencer states, encoding visible on o_state
//   - PC_W_DEF    : default width of the PC path and breakpoint address
//   - CNT_W_DEF   : default width of the cycle / retired counters
//   - BOOT_CNT_W  : width of the post-reset hold counter (BOOT_HOLD <= 255)
//   The optional breakpoint unit is built when CORE_RUN_CTRL_BP_EN is defined.
package core_run_ctrl_pkg;

  localparam int unsigned PC_W_DEF   = 32;
  localparam int unsigned CNT_W_DEF  = 32;
  localparam int unsigned BOOT_CNT_W = 8;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2,
    STEP = 2'd3
  } run_state_e;

endpackage

// File: rtl/core_run_bp.sv
// core_run_bp
//   Breakpoint unit: holds the breakpoint address, compares it against the
//   current PC and owns the skip flag that lets execution resume from a
//   breakpoint address without re-triggering on the same instruction.
//   Only instantiated when CORE_RUN_CTRL_BP_EN is defined.
//   Ports:
//     i_clk, i_rst    clock, asynchronous active-high reset
//     i_bp_wr         load i_bp_addr into the breakpoint register
//     i_bp_addr       new breakpoint address
//     i_bp_en         compare enable (level)
//     i_pc            current PC
//     i_skip_set      sequencer is resuming (RUN or STEP) out of HALT
//     i_pc_en         PC advances this cycle
//     o_bp_match      breakpoint hit this cycle
module core_run_bp
  import core_run_ctrl_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_bp_wr,
  input  logic [PC_W-1:0] i_bp_addr,
  input  logic            i_bp_en,
  input  logic [PC_W-1:0] i_pc,
  input  logic            i_skip_set,
  input  logic            i_pc_en,
  output logic            o_bp_match
);

  logic [PC_W-1:0] bp_q, bp_d;
  logic            skip_q, skip_d;

  always_comb begin
    bp_d   = bp_q;
    skip_d = skip_q;
    if (i_bp_wr) bp_d = i_bp_addr;
    // Set only happens out of HALT where the PC is frozen, so set and clear
    // never compete; the skip survives exactly until one instruction retires.
    if (i_skip_set)   skip_d = 1'b1;
    else if (i_pc_en) skip_d = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bp_q   <= '0;
      skip_q <= 1'b0;
    end else begin
      bp_q   <= bp_d;
      skip_q <= skip_d;
    end
  end

  // Compare uses the registered address, so a same-cycle write is not seen.
  assign o_bp_match = i_bp_en & (i_pc == bp_q) & ~skip_q;

endmodule

// File: rtl/core_run_ctrl.sv
// core_run_ctrl
//   Run/halt/single-step sequencer for the single-cycle RV32I core. Produces
//   the PC-advance enable and the matching write-enable mask so the datapath
//   can be frozen, stepped or stopped at a breakpoint, plus cycle and
//   retired-instruction counters.
//   Optional breakpoint support: define CORE_RUN_CTRL_BP_EN. Without it the
//   breakpoint inputs are ignored and o_bp_hit is constant 0.
//   Ports:
//     i_clk, i_rst     clock, asynchronous active-high reset
//     i_run_req        pulse: enter RUN (from HALT)
//     i_halt_req       pulse: enter HALT (from RUN)
//     i_step_req       pulse: execute one instruction (from HALT)
//     i_bp_wr/addr/en  breakpoint load, address, compare enable
//     i_pc             current PC
//     i_insn_vld       current instruction valid
//     o_pc_en          PC may advance this cycle
//     o_wr_en          write-enable mask, equal to o_pc_en
//     o_state          current state encoding (BOOT/RUN/HALT/STEP)
//     o_halted         state is HALT
//     o_bp_hit         sticky: last halt was caused by a breakpoint
//     o_cycles         cycles spent outside BOOT
//     o_retired        retired valid instructions
module core_run_ctrl
  import core_run_ctrl_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int BOOT_HOLD = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run_req,
  input  logic             i_halt_req,
  input  logic             i_step_req,
  input  logic             i_bp_wr,
  input  logic [PC_W-1:0]  i_bp_addr,
  input  logic             i_bp_en,
  input  logic [PC_W-1:0]  i_pc,
  input  logic             i_insn_vld,
  output logic             o_pc_en,
  output logic             o_wr_en,
  output logic [1:0]       o_state,
  output logic             o_halted,
  output logic             o_bp_hit,
  output logic [CNT_W-1:0] o_cycles,
  output logic [CNT_W-1:0] o_retired
);

  localparam logic [BOOT_CNT_W-1:0] BOOT_LAST = BOOT_CNT_W'(BOOT_HOLD - 1);

  run_state_e             state_q, state_d;
  logic [BOOT_CNT_W-1:0]  boot_cnt_q, boot_cnt_d;
  logic                   bp_hit_q, bp_hit_d;
  logic [CNT_W-1:0]       cycles_q, cycles_d;
  logic [CNT_W-1:0]       retired_q, retired_d;
  logic                   skip_set;
  logic                   bp_match;
  logic                   pc_en;

`ifdef CORE_RUN_CTRL_BP_EN
  core_run_bp #(
    .PC_W (PC_W)
  ) u_bp (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_bp_wr    (i_bp_wr),
    .i_bp_addr  (i_bp_addr),
    .i_bp_en    (i_bp_en),
    .i_pc       (i_pc),
    .i_skip_set (skip_set),
    .i_pc_en    (pc_en),
    .o_bp_match (bp_match)
  );
`else
  assign bp_match = 1'b0;

  logic unused_bp_inputs;
  assign unused_bp_inputs = ^{i_bp_wr, i_bp_addr, i_bp_en, i_pc, skip_set};
`endif

  // A breakpoint match blocks the instruction at the breakpoint address in
  // the same cycle; STEP always executes its one instruction.
  assign pc_en = ((state_q == RUN) & ~bp_match) | (state_q == STEP);

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    bp_hit_d   = bp_hit_q;
    skip_set   = 1'b0;
    unique case (state_q)
      BOOT: begin
        boot_cnt_d = boot_cnt_q + 1'b1;
        if (boot_cnt_q == BOOT_LAST) state_d = RUN;
      end
      RUN: begin
        if (bp_match) begin
          state_d  = HALT;
          bp_hit_d = 1'b1;
        end else if (i_halt_req) begin
          state_d = HALT;
        end
      end
      HALT: begin
        // halt > step > run; a halt request simply keeps us here
        if (!i_halt_req) begin
          if (i_step_req) begin
            state_d  = STEP;
            skip_set = 1'b1;
          end else if (i_run_req) begin
            state_d  = RUN;
            skip_set = 1'b1;
            bp_hit_d = 1'b0;
          end
        end
      end
      STEP: state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  // The cycle counter counts the cycle being entered, so the first RUN
  // cycle already reads 1.
  assign cycles_d  = cycles_q  + {{(CNT_W-1){1'b0}}, (state_d != BOOT)};
  assign retired_d = retired_q + {{(CNT_W-1){1'b0}}, (pc_en & i_insn_vld)};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= BOOT;
      boot_cnt_q <= '0;
      bp_hit_q   <= 1'b0;
      cycles_q   <= '0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      bp_hit_q   <= bp_hit_d;
      cycles_q   <= cycles_d;
      retired_q  <= retired_d;
    end
  end

  assign o_pc_en   = pc_en;
  assign o_wr_en   = pc_en;
  assign o_state   = state_q;
  assign o_halted  = (state_q == HALT);
  assign o_bp_hit  = bp_hit_q;
  assign o_cycles  = cycles_q;
  assign o_retired = retired_q;

endmodule
